lbp_hist: RTL and testbench

- Downstream consumer of the LBP stage. Snoops its pixel-write stream (lbp_valid, lbp_data, finish) and builds a 256-bin histogram of LBP codes over the 126x126 interior (15876 codes).
- After finish, streams the histogram out bin by bin over a valid/ready handshake to the feature/classifier stage.
- Sits beside the LBP result memory and does not back-pressure the LBP stage.

---
 rtl/lbp_pkg.sv | 10 +
 rtl/hist_ram.sv | 20 ++
 rtl/lbp_hist.sv | 112 +++++++++++
 tb/tb_lbp_hist.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Constants and types shared by the LBP stage, the histogram block and the classifier.
package lbp_pkg;
  localparam int IMG_W      = 128;
  localparam int BIN_W      = 8;
  localparam int BIN_N      = 2 ** BIN_W;
  localparam int CNT_W      = 14;
  localparam int INTERIOR_N = (IMG_W - 2) * (IMG_W - 2);

  typedef enum logic [1:0] {ACC, DRAIN, OUT, DONE} state_e;
endpackage

// File: rtl/hist_ram.sv
// Histogram storage: one write port, one registered read port, no reset.
module hist_ram #(
  parameter int AW = lbp_pkg::BIN_W,
  parameter int DW = lbp_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/lbp_hist.sv
// Builds a histogram of LBP codes from the snooped write stream, then streams it out
// bin by bin over valid/ready once finish is seen.
module lbp_hist #(
  parameter int BIN_W = lbp_pkg::BIN_W,
  parameter int CNT_W = lbp_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [BIN_W-1:0] lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [BIN_W-1:0] hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic [CNT_W-1:0] total_count,
  output logic             hist_done
);
  import lbp_pkg::*;

  state_e               state;
  logic [2**BIN_W-1:0]  touched;
  logic                 s2_valid;
  logic                 s2_fwd;
  logic [BIN_W-1:0]     s2_bin;
  logic [CNT_W-1:0]     s2_fwd_val;
  logic [BIN_W-1:0]     rd_ptr;
  logic                 pres_touched;

  logic                 s1_go;
  logic                 accept;
  logic                 last_accept;
  logic                 out_issue;
  logic                 ram_re;
  logic [BIN_W-1:0]     ram_raddr;
  logic [CNT_W-1:0]     rdata;
  logic [CNT_W-1:0]     old_cnt;
  logic [CNT_W-1:0]     new_cnt;

  assign s1_go       = (state == ACC) && lbp_valid;
  assign accept      = hist_valid && hist_ready;
  assign last_accept = accept && (hist_bin == {BIN_W{1'b1}});
  assign out_issue   = (state == OUT) && (!hist_valid || hist_ready) && !last_accept;

  assign ram_re    = s1_go || out_issue;
  assign ram_raddr = (state == OUT) ? rd_ptr : lbp_data;

  // Untouched bins read as zero, so the RAM never needs a clear pass.
  assign old_cnt    = s2_fwd ? s2_fwd_val : (touched[s2_bin] ? rdata : '0);
  assign new_cnt    = old_cnt + CNT_W'(1);
  assign hist_count = pres_touched ? rdata : '0;

  hist_ram #(.AW(BIN_W), .DW(CNT_W)) u_ram (
    .clk   (clk),
    .we    (s2_valid),
    .waddr (s2_bin),
    .wdata (new_cnt),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ACC;
      touched      <= '0;
      s2_valid     <= 1'b0;
      s2_fwd       <= 1'b0;
      s2_bin       <= '0;
      s2_fwd_val   <= '0;
      rd_ptr       <= '0;
      pres_touched <= 1'b0;
      hist_valid   <= 1'b0;
      hist_bin     <= '0;
      total_count  <= '0;
      hist_done    <= 1'b0;
    end else begin
      s2_valid   <= s1_go;
      s2_bin     <= lbp_data;
      // Same bin in S1 and S2: RAM read is stale, take the value S2 is writing now.
      s2_fwd     <= s1_go && s2_valid && (lbp_data == s2_bin);
      s2_fwd_val <= new_cnt;
      if (s2_valid) begin
        touched[s2_bin] <= 1'b1;
        total_count     <= total_count + CNT_W'(1);
      end

      case (state)
        ACC: begin
          if (finish) state <= DRAIN;
        end
        DRAIN: begin
          rd_ptr <= '0;
          state  <= OUT;
        end
        OUT: begin
          if (last_accept) begin
            hist_valid <= 1'b0;
            hist_done  <= 1'b1;
            state      <= DONE;
          end else if (out_issue) begin
            hist_valid   <= 1'b1;
            hist_bin     <= rd_ptr;
            pres_touched <= touched[rd_ptr];
            rd_ptr       <= rd_ptr + BIN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: accumulation, forwarding, full image, stalls, async reset.
module tb_lbp_hist;
  import lbp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        lbp_valid;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_valid;
  logic        hist_ready;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count;
  logic [13:0] total_count;
  logic        hist_done;

  int total = 0;
  int bad   = 0;
  int exp_hist [256];
  int got      [256];
  int exp_total;

  always #5 clk = ~clk;

  lbp_hist dut (
    .clk         (clk),
    .reset       (reset),
    .lbp_valid   (lbp_valid),
    .lbp_data    (lbp_data),
    .finish      (finish),
    .hist_valid  (hist_valid),
    .hist_ready  (hist_ready),
    .hist_bin    (hist_bin),
    .hist_count  (hist_count),
    .total_count (total_count),
    .hist_done   (hist_done)
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) begin
      exp_hist[i] = 0;
      got[i]      = -1;
    end
    exp_total = 0;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    lbp_valid  = 1'b0;
    finish     = 1'b0;
    hist_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_model();
  endtask

  // Called at a negedge; holds the code for exactly one rising edge.
  task automatic put_code(input logic [7:0] c);
    lbp_valid = 1'b1;
    lbp_data  = c;
    exp_hist[c]++;
    exp_total++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    lbp_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // mode 0: ready held high; mode 1: random ready plus a 20-cycle stall at bin 17.
  // last_code >= 0 strobes that code in the same cycle finish first rises.
  task automatic read_hist(input int mode, input int last_code);
    int cycles, next_bin, sum, first_v, last_acc, stall17, held_bin, held_cnt;
    bit stalled;
    cycles = 0; next_bin = 0; sum = 0; first_v = -1; last_acc = -1; stall17 = 0;
    held_bin = 0; held_cnt = 0; stalled = 1'b0;
    finish = 1'b1;
    if (last_code >= 0) begin
      lbp_valid = 1'b1;
      lbp_data  = last_code[7:0];
      exp_hist[last_code]++;
      exp_total++;
    end
    hist_ready = (mode == 0);
    while (!hist_done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      lbp_valid = 1'b0;
      if (hist_valid && first_v < 0) first_v = cycles;
      if (stalled) begin
        check("stall_bin", int'(hist_bin), held_bin);
        check("stall_cnt", int'(hist_count), held_cnt);
      end
      if (mode == 0) hist_ready = 1'b1;
      else if (hist_valid && hist_bin == 8'd17 && stall17 < 20) begin
        hist_ready = 1'b0;
        stall17++;
      end else hist_ready = 1'($urandom_range(0, 1));
      stalled  = hist_valid && !hist_ready;
      held_bin = int'(hist_bin);
      held_cnt = int'(hist_count);
      if (hist_valid && hist_ready) begin
        check($sformatf("order%0d", next_bin), int'(hist_bin), next_bin);
        check($sformatf("bin%0d", hist_bin), int'(hist_count), exp_hist[hist_bin]);
        got[hist_bin] = int'(hist_count);
        sum += int'(hist_count);
        if (hist_bin == 8'd255) last_acc = cycles;
        next_bin++;
      end
    end
    check("done", int'(hist_done), 1);
    check("bins_accepted", next_bin, 256);
    check("total_count", int'(total_count), exp_total);
    check("count_sum", sum, exp_total);
    check("valid_after_done", int'(hist_valid), 0);
    check("first_valid_lat", first_v, 3);
    if (mode == 0) check("throughput", last_acc, 258);
    if (mode == 1) check("stall17_len", stall17, 20);
    $display("hist read: mode=%0d bins=%0d total=%0d cycles=%0d", mode, next_bin, total_count, cycles);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, prev, bincnt;
    reset = 1'b1; lbp_valid = 1'b0; lbp_data = '0; finish = 1'b0; hist_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", int'(hist_valid), 0);
    check("rst_bin", int'(hist_bin), 0);
    check("rst_count", int'(hist_count), 0);
    check("rst_total", int'(total_count), 0);
    check("rst_done", int'(hist_done), 0);
    apply_reset();

    // Empty image
    read_hist(0, -1);
    check("t1_bin0", got[0], 0);
    check("t1_bin255", got[255], 0);
    repeat (5) @(negedge clk);
    check("t1_frozen_done", int'(hist_done), 1);
    check("t1_frozen_valid", int'(hist_valid), 0);
    check("t1_frozen_bin", int'(hist_bin), 255);

    // Sparse codes
    apply_reset();
    put_code(8'h00); idle(10);
    put_code(8'hFF); idle(10);
    put_code(8'h00); idle(10);
    read_hist(0, -1);
    check("t2_bin0", got[0], 2);
    check("t2_bin255", got[255], 1);
    check("t2_bin1", got[1], 0);
    check("t2_total", int'(total_count), 3);

    // Back-to-back same bin exercises forwarding
    apply_reset();
    repeat (5) put_code(8'h5A);
    put_code(8'h5B);
    put_code(8'h5A);
    idle(1);
    read_hist(0, -1);
    check("t3_bin5a", got[8'h5A], 6);
    check("t3_bin5b", got[8'h5B], 1);
    check("t3_total", int'(total_count), 7);

    // Full image, random ready, last code coincides with finish
    apply_reset();
    prev = 0;
    for (int i = 0; i < INTERIOR_N - 1; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) c = prev;
      else c = int'($urandom_range(0, 255));
      put_code(c[7:0]);
      prev = c;
      if (i % 97 == 0) idle(1);
    end
    idle(1);
    read_hist(1, 17);
    check("t4_total", int'(total_count), INTERIOR_N);
    bincnt = 0;
    for (int i = 0; i < 256; i++) if (got[i] >= 0) bincnt++;
    check("t4_all_bins_seen", bincnt, 256);

    // Async reset mid-output, then a fresh 4-code image
    apply_reset();
    put_code(8'h40); put_code(8'h41);
    idle(2);
    finish = 1'b1;
    hist_ready = 1'b1;
    c = 0;
    while (!(hist_valid && hist_bin == 8'd100) && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("t5_reach_bin100", int'(hist_bin), 100);
    #2 reset = 1'b1;
    #1;
    check("t5_async_valid", int'(hist_valid), 0);
    check("t5_async_total", int'(total_count), 0);
    @(negedge clk);
    reset = 1'b0; finish = 1'b0; hist_ready = 1'b0;
    @(negedge clk);
    clear_model();
    put_code(8'h11); put_code(8'h22); put_code(8'h11); put_code(8'h33);
    idle(2);
    read_hist(0, -1);
    check("t5_bin11", got[8'h11], 2);
    check("t5_bin22", got[8'h22], 1);
    check("t5_bin33", got[8'h33], 1);
    check("t5_bin40", got[8'h40], 0);
    check("t5_total", int'(total_count), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
